param_data_mem: RTL and testbench

Parametrised single-port synchronous data memory, the successor to the fixed 8x256 data memory used by the multi-cycle datapath. It adds configurable data width, address width and depth, plus per-byte write enables. Reads are registered, with a valid strobe and write-first forwarding. After reset, a hardware clear engine zero-fills the array and reports Busy. Out-of-range accesses are flagged.

---
 rtl/param_data_mem_if.sv | 28 ++
 rtl/param_data_mem.sv | 161 ++++++++++++++++
 tb/tb_param_data_mem.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_data_mem_if.sv
// Request/response bundle for param_data_mem.
//   master: drives Address, WriteData, ByteEn, MemWrite, MemRead;
//           receives ReadData, ReadValid, Busy, ErrAddr.
//   slave : the memory side, with the opposite directions.
interface param_data_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]   Address;
  logic [DATA_W-1:0]   WriteData;
  logic [DATA_W/8-1:0] ByteEn;
  logic                MemWrite;
  logic                MemRead;
  logic [DATA_W-1:0]   ReadData;
  logic                ReadValid;
  logic                Busy;
  logic                ErrAddr;

  modport master (
    output Address, WriteData, ByteEn, MemWrite, MemRead,
    input  ReadData, ReadValid, Busy, ErrAddr
  );

  modport slave (
    input  Address, WriteData, ByteEn, MemWrite, MemRead,
    output ReadData, ReadValid, Busy, ErrAddr
  );
endinterface

// File: rtl/param_data_mem.sv
// Parametrised single-port synchronous data memory.
//   Clk, Rst  : clock and asynchronous active-high reset
//   bus.slave : Address/WriteData/ByteEn/MemWrite/MemRead in,
//               ReadData/ReadValid/Busy/ErrAddr out (all registered)
// Byte-lane write enables, 1-cycle registered read with write-first
// forwarding, a post-reset clear engine (Busy) and out-of-range flagging.

// One byte lane of the write merge: the new byte when enabled, else the old one.
module param_data_mem_lane (
  input  logic       en_i,
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  output logic [7:0] out_o
);
  assign out_o = en_i ? new_i : old_i;
endmodule

module param_data_mem #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 8,
  parameter int                DEPTH          = 256,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input logic           Clk,
  input logic           Rst,
  param_data_mem_if.slave bus
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STAGES    = 1;
  // DEPTH may equal 2**ADDR_W, so compare with one spare bit
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("param_data_mem: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $error("param_data_mem: DEPTH must be in 1 .. 2**ADDR_W");
  end

  typedef enum logic {S_CLEAR, S_IDLE} state_e;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [NUM_LANES-1:0] be;
    logic                 we;
    logic                 re;
  } req_t;

  req_t req;
  assign req = {bus.Address, bus.WriteData, bus.ByteEn, bus.MemWrite, bus.MemRead};

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;

  logic                 idle, in_range, rd_acc;
  logic [IDX_W-1:0]     rd_idx;
  logic [DATA_W-1:0]    old_word, merged_word;
  logic [NUM_LANES-1:0] lane_en;

  assign idle     = (state_q == S_IDLE);
  assign in_range = {1'b0, req.addr} < DEPTH_X;
  // Out-of-range addresses never index the array
  assign rd_idx   = in_range ? req.addr[IDX_W-1:0] : '0;
  assign old_word = mem[rd_idx];
  assign lane_en  = req.we ? req.be : '0;

  // Merged word serves both the array update and the write-first read result
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    param_data_mem_lane u_lane (
      .en_i  (lane_en[k]),
      .old_i (old_word[8*k +: 8]),
      .new_i (req.wdata[8*k +: 8]),
      .out_o (merged_word[8*k +: 8])
    );
  end

  // Clear engine: one word per cycle, leaves CLEAR on the edge writing the last word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      if (cnt_q == LAST_IDX) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end
  end

  // Single array write port shared by the clear engine and IDLE writes.
  // Rst gates it so a reset never disturbs the contents.
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = rd_idx;
    mem_wdata = merged_word;
    if (!Rst) begin
      if (state_q == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_widx  = cnt_q;
        mem_wdata = CLEAR_VALUE;
      end else if (req.we && in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Read/err results: zero unless a read (or access) was accepted in IDLE
  assign rd_acc = idle & req.re;

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (idle) begin
      if (req.re && in_range)           rdata_d = merged_word;
      if ((req.re || req.we) && !in_range) err_d = 1'b1;
    end
  end

  assign vld_pipe = {vld_q, rd_acc};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      vld_q   <= vld_pipe[STAGES-1:0];
    end
  end

  assign bus.ReadData  = rdata_q;
  assign bus.ReadValid = vld_pipe[STAGES];
  assign bus.Busy      = (state_q == S_CLEAR);
  assign bus.ErrAddr   = err_q;
endmodule

// File: tb/tb_param_data_mem.sv
// Bench for param_data_mem: three instances share one stimulus bus
//   u_a: defaults (DEPTH 256, clear to 0)
//   u_b: DEPTH 200, clear value A5A50F0F
//   u_c: no clear on reset
// Each expected response names the instance it belongs to.
module tb_param_data_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [7:0]  addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        we, re;

  localparam logic [31:0] CV_B = 32'hA5A5_0F0F;

  param_data_mem_if #(.DATA_W(32), .ADDR_W(8)) bus_a ();
  param_data_mem_if #(.DATA_W(32), .ADDR_W(8)) bus_b ();
  param_data_mem_if #(.DATA_W(32), .ADDR_W(8)) bus_c ();

  assign bus_a.Address = addr; assign bus_a.WriteData = wd; assign bus_a.ByteEn = be;
  assign bus_a.MemWrite = we;  assign bus_a.MemRead = re;
  assign bus_b.Address = addr; assign bus_b.WriteData = wd; assign bus_b.ByteEn = be;
  assign bus_b.MemWrite = we;  assign bus_b.MemRead = re;
  assign bus_c.Address = addr; assign bus_c.WriteData = wd; assign bus_c.ByteEn = be;
  assign bus_c.MemWrite = we;  assign bus_c.MemRead = re;

  param_data_mem u_a (.Clk(clk), .Rst(rst_a), .bus(bus_a));
  param_data_mem #(.DEPTH(200), .CLEAR_VALUE(CV_B)) u_b (.Clk(clk), .Rst(rst_b), .bus(bus_b));
  param_data_mem #(.CLEAR_ON_RESET(0)) u_c (.Clk(clk), .Rst(rst_c), .bus(bus_c));

  logic [31:0] rd [3];
  logic [2:0]  vld, err, busy;
  assign rd[0] = bus_a.ReadData; assign rd[1] = bus_b.ReadData; assign rd[2] = bus_c.ReadData;
  assign vld  = {bus_c.ReadValid, bus_b.ReadValid, bus_a.ReadValid};
  assign err  = {bus_c.ErrAddr,   bus_b.ErrAddr,   bus_a.ErrAddr};
  assign busy = {bus_c.Busy,      bus_b.Busy,      bus_a.Busy};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          dut;
    logic        vld;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          dut;
    logic        w, r;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] xd;
    logic        xv, xe;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int d, logic w, logic r, logic [7:0] a, logic [31:0] wdat,
                              logic [3:0] b, logic [31:0] xd, logic xv, logic xe);
    vec_t v;
    v.dut = d; v.w = w; v.r = r; v.a = a; v.wd = wdat; v.be = b;
    v.xd = xd; v.xv = xv; v.xe = xe;
    return v;
  endfunction

  // Drive one request on the falling edge and queue its expected response
  task automatic op(int d, logic w, logic r, logic [7:0] a, logic [31:0] wdat,
                    logic [3:0] b, logic [31:0] xd, logic xv, logic xe);
    exp_t e;
    @(negedge clk);
    we = w; re = r; addr = a; wd = wdat; be = b;
    e.dut = d; e.vld = xv; e.data = xd; e.err = xe;
    sbq.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  // Monitor: one response per queued request, sampled 1 time unit after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("ReadValid[dut%0d]", e.dut), {31'b0, vld[e.dut]}, {31'b0, e.vld});
      chk($sformatf("ReadData[dut%0d]",  e.dut), rd[e.dut], e.data);
      chk($sformatf("ErrAddr[dut%0d]",   e.dut), {31'b0, err[e.dut]}, {31'b0, e.err});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  int cnt_a, cnt_b;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    we = 1'b0; re = 1'b0; addr = '0; wd = '0; be = '0;

    // Table: DUT A main function, then DUT B out-of-range corners
    tbl.push_back(mk(0, 0, 1, 8'h00, 32'h0, 4'h0, 32'h0000_0000, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h7F, 32'h0, 4'h0, 32'h0000_0000, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hFF, 32'h0, 4'h0, 32'h0000_0000, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h10, 32'h1122_3344, 4'h5, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h20, 32'hAAAA_AAAA, 4'hF, 32'h0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h20, 32'h5555_5555, 4'h3, 32'hAAAA_5555, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h20, 32'h0, 4'h0, 32'hAAAA_5555, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h30, 32'h1234_5678, 4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h30, 32'h0, 4'h0, 32'h0000_0000, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h30, 32'hFFEE_DDCC, 4'h8, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h30, 32'h0, 4'h0, 32'hFF00_0000, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h40, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h40, 32'h0, 4'h0, 32'h0BAD_F00D, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h10, 32'h0, 4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'hC8, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 8'hC8, 32'h0, 4'h0, 32'h0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 8'hC7, 32'h0, 4'h0, CV_B, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'hC7, 32'h1357_2468, 4'hF, 32'h0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 8'hC7, 32'h0, 4'h0, 32'h1357_2468, 1, 0));
    tbl.push_back(mk(1, 0, 1, 8'hFF, 32'h0, 4'h0, 32'h0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 8'hC8, 32'h1234_5678, 4'hF, 32'h0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 8'h00, 32'h0000_00EE, 4'h1, 32'hA5A5_0FEE, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h05, 32'h0, 4'h0, 32'h0, 0, 0));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ReadData_a",  rd[0], 32'h0);
    chk("rst_ReadValid_a", {31'b0, vld[0]}, 32'h0);
    chk("rst_ErrAddr_a",   {31'b0, err[0]}, 32'h0);
    chk("rst_Busy_a",      {31'b0, busy[0]}, 32'h1);
    chk("rst_Busy_b",      {31'b0, busy[1]}, 32'h1);
    chk("rst_Busy_c",      {31'b0, busy[2]}, 32'h0);

    // Release and measure clear duration
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    chk("post_rst_Busy_c", {31'b0, busy[2]}, 32'h0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy[0]) cnt_a++;
      if (busy[1]) cnt_b++;
      if (!busy[0] && !busy[1]) break;
      @(negedge clk);
    end
    chk("busy_cycles_a", cnt_a, 256);
    chk("busy_cycles_b", cnt_b, 200);

    // Table-driven vectors, back to back
    for (int i = 0; i < tbl.size(); i++)
      op(tbl[i].dut, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].be,
         tbl[i].xd, tbl[i].xv, tbl[i].xe);
    idle_cycle();
    idle_cycle();

    // Reset A at clear cycle 100 with requests held active
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    we = 1'b1; re = 1'b1; addr = 8'hC7; wd = 32'hFFFF_FFFF; be = 4'hF;
    rst_a = 1'b1;
    #1;
    chk("midclear_rst_ReadValid_a", {31'b0, vld[0]}, 32'h0);
    chk("midclear_rst_ReadData_a",  rd[0], 32'h0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy[0]) cnt_a++;
      else break;
      if (i == 50) chk("clear_drops_read_a", {31'b0, vld[0]}, 32'h0);
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;
    chk("busy_cycles_restart_a", cnt_a, 256);
    chk("clear_end_ReadValid_a", {31'b0, vld[0]}, 32'h0);
    op(0, 0, 1, 8'hC7, 32'h0, 4'h0, 32'h0, 1, 0);
    op(0, 0, 1, 8'hC8, 32'h0, 4'h0, 32'h0, 1, 0);
    op(0, 0, 1, 8'h00, 32'h0, 4'h0, 32'h0, 1, 0);
    op(0, 0, 1, 8'h10, 32'h0, 4'h0, 32'h0, 1, 0);
    op(0, 0, 1, 8'hFF, 32'h0, 4'h0, 32'h0, 1, 0);
    idle_cycle();
    idle_cycle();

    // DUT C: contents survive reset, no clear phase
    op(2, 1, 0, 8'h05, 32'h5A5A_A5A5, 4'hF, 32'h0, 0, 0);
    op(2, 0, 1, 8'h05, 32'h0, 4'h0, 32'h5A5A_A5A5, 1, 0);
    idle_cycle();
    idle_cycle();
    rst_c = 1'b1;
    #1;
    chk("rst_Busy_c_again",  {31'b0, busy[2]}, 32'h0);
    chk("rst_ReadValid_c",   {31'b0, vld[2]}, 32'h0);
    @(negedge clk);
    rst_c = 1'b0;
    chk("post_rst_Busy_c_again", {31'b0, busy[2]}, 32'h0);
    op(2, 0, 1, 8'h05, 32'h0, 4'h0, 32'h5A5A_A5A5, 1, 0);
    op(2, 1, 1, 8'h05, 32'h1234_0000, 4'hC, 32'h1234_A5A5, 1, 0);
    op(2, 0, 1, 8'h05, 32'h0, 4'h0, 32'h1234_A5A5, 1, 0);
    repeat (3) idle_cycle();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
